// File: rtl/load_store_unit.sv
// Single-request load/store unit: byte/half/word/dword accesses with sign extension and
// read-modify-write narrow stores. Define MEM_ALIGN_CHECK_EN to reject misaligned accesses.
module load_store_unit #(
  parameter int unsigned SIZE = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic [63:0] mem_address,
  output logic [63:0] mem_d_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_d_out
);

  typedef enum logic [2:0] {StIdle, StRd, StRmwRd, StWr, StResp} state_e;

  localparam logic [63:0] Limit = 64'(SIZE) - 64'd8;

  state_e      r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_error;

  logic        w_req_err;
  logic [63:0] w_mask;
  logic [63:0] w_ld;
  logic [63:0] w_merged;

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      default: w_misalign = |req_addr[2:0];
    endcase
  end

  assign w_req_err = (req_addr > Limit) | w_misalign;
`else
  assign w_req_err = req_addr > Limit;
`endif

  always_comb begin
    w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    w_ld   = mem_d_out;
    case (r_size)
      2'b00: begin
        w_mask = 64'h0000_0000_0000_00FF;
        w_ld   = r_signed ? {{56{mem_d_out[7]}}, mem_d_out[7:0]} : {56'd0, mem_d_out[7:0]};
      end
      2'b01: begin
        w_mask = 64'h0000_0000_0000_FFFF;
        w_ld   = r_signed ? {{48{mem_d_out[15]}}, mem_d_out[15:0]} : {48'd0, mem_d_out[15:0]};
      end
      2'b10: begin
        w_mask = 64'h0000_0000_FFFF_FFFF;
        w_ld   = r_signed ? {{32{mem_d_out[31]}}, mem_d_out[31:0]} : {32'd0, mem_d_out[31:0]};
      end
      default: begin
        w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        w_ld   = mem_d_out;
      end
    endcase
  end

  // Bytes outside the access keep exactly what was read back.
  assign w_merged = (mem_d_out & ~w_mask) | (r_wdata & w_mask);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 64'd0;
      r_wdata  <= 64'd0;
      r_rdata  <= 64'd0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_state <= StResp;
              r_error <= 1'b1;
              r_rdata <= 64'd0;
            end else if (!req_write) begin
              r_state <= StRd;
            end else if (req_size == 2'b11) begin
              r_state <= StWr;
            end else begin
              r_state <= StRmwRd;
            end
          end
        end
        StRd: begin
          r_rdata <= w_ld;
          r_error <= 1'b0;
          r_state <= StResp;
        end
        StRmwRd: begin
          r_wdata <= w_merged;
          r_state <= StWr;
        end
        StWr: begin
          r_rdata <= 64'd0;
          r_error <= 1'b0;
          r_state <= StResp;
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready   = (r_state == StIdle);
  assign rsp_valid   = (r_state == StResp);
  assign rsp_rdata   = r_rdata;
  assign rsp_error   = r_error;
  assign mem_address = r_addr;
  assign mem_d_in    = r_wdata;
  assign mem_read    = (r_state == StRd) || (r_state == StRmwRd);
  assign mem_write   = (r_state == StWr);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses against a 256-byte memory model
// preloaded with mem[i]=i; a monitor pops expected responses whenever rsp_valid is seen.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic [63:0] mem_address;
  logic [63:0] mem_d_in;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_d_out;

  load_store_unit #(.SIZE(256)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_address (mem_address),
    .mem_d_in    (mem_d_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_d_out   (mem_d_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: little-endian, combinational read, dword write on the rising edge.
  logic [7:0] mem [256];
  logic       mem_init = 1'b0;

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++) mem[8'(mem_address[7:0] + 8'(i))] <= mem_d_in[8*i +: 8];
    end
  end

  always_comb begin
    mem_d_out = 64'd0;
    for (int i = 0; i < 8; i++) mem_d_out[8*i +: 8] = mem[8'(mem_address[7:0] + 8'(i))];
  end

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   rd_count = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one request; when expect_rsp is set, push the response it must produce.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err, input int exp_lat,
                       input logic expect_rsp);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {63'd0, req_ready}, 64'd1);
    end
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    if (expect_rsp) begin
      e.rd  = exp_rd;
      e.err = exp_err;
      e.lat = exp_lat;
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      chk("rsp_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [63:0] addr,
                    input logic [63:0] exp_rd, input logic exp_err, input int exp_lat);
    issue(1'b0, sz, sg, addr, 64'd0, exp_rd, exp_err, exp_lat, 1'b1);
    wait_idle();
  endtask

  task automatic st(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd,
                    input logic exp_err, input int exp_lat);
    issue(1'b1, sz, 1'b0, addr, wd, 64'd0, exp_err, exp_lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    int rd_snap;
    fork
      forever begin
        exp_t e;
        @(negedge clock);
        if (mem_read) rd_count++;
        if (mem_read && mem_write) chk("rd_wr_exclusive", 64'd1, 64'd0);
        if (reset_n && rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
            chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
    chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_d_in", mem_d_in, 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Loads
    ld(2'b11, 1'b0, 64'h10, 64'h1716151413121110, 1'b0, 1);
    repeat (3) @(negedge clock);
    chk("rdata_hold", rsp_rdata, 64'h1716151413121110);
    ld(2'b00, 1'b1, 64'h80, 64'hFFFFFFFFFFFFFF80, 1'b0, 1);
    ld(2'b00, 1'b0, 64'h80, 64'h0000000000000080, 1'b0, 1);
    ld(2'b01, 1'b1, 64'h7E, 64'h0000000000007F7E, 1'b0, 1);
    ld(2'b01, 1'b1, 64'h80, 64'hFFFFFFFFFFFF8180, 1'b0, 1);
    ld(2'b10, 1'b1, 64'hF8, 64'hFFFFFFFFFBFAF9F8, 1'b0, 1);
    ld(2'b10, 1'b0, 64'hF8, 64'h00000000FBFAF9F8, 1'b0, 1);
    ld(2'b11, 1'b1, 64'hF8, 64'hFFFEFDFCFBFAF9F8, 1'b0, 1);

    // Range error: no memory read may be issued
    rd_snap = rd_count;
    ld(2'b00, 1'b0, 64'hF9, 64'd0, 1'b1, 0);
    chk("err_no_mem_read", 64'(rd_count - rd_snap), 64'd0);
    st(2'b11, 64'h100, 64'h1111, 1'b1, 0);

`ifdef MEM_ALIGN_CHECK_EN
    ld(2'b10, 1'b0, 64'h02, 64'd0, 1'b1, 0);
`else
    ld(2'b10, 1'b0, 64'h02, 64'h0000000005040302, 1'b0, 1);
`endif

    // Stores and read-back
    st(2'b01, 64'h20, 64'h123456789ABCBEEF, 1'b0, 2);
    ld(2'b11, 1'b0, 64'h20, 64'h272625242322BEEF, 1'b0, 1);
    st(2'b00, 64'h30, 64'h55AA, 1'b0, 2);
    ld(2'b11, 1'b0, 64'h30, 64'h37363534333231AA, 1'b0, 1);
    st(2'b10, 64'h50, 64'hCAFEDEADBEEF, 1'b0, 2);
    ld(2'b11, 1'b0, 64'h50, 64'h57565554DEADBEEF, 1'b0, 1);
    st(2'b11, 64'h60, 64'h0123456789ABCDEF, 1'b0, 1);
    ld(2'b11, 1'b0, 64'h60, 64'h0123456789ABCDEF, 1'b0, 1);

    // Reset in the middle of a dword store must suppress the write and the response
    issue(1'b1, 2'b11, 1'b0, 64'h40, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 0, 1'b0);
    chk("wr_state_mem_write", {63'd0, mem_write}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_write", {63'd0, mem_write}, 64'd0);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_rsp_rdata", rsp_rdata, 64'd0);
    chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    ld(2'b11, 1'b0, 64'h40, 64'h4746454443424140, 1'b0, 1);

    repeat (3) @(negedge clock);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter SIZE, default 256: byte depth of the downstream memory, used for the range check.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  unit idle and able to accept a request.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_size  in  2  access size: 00 byte, 01 half (2B), 10 word (4B), 11 dword (8B).
REQ-008 req_signed  in  1  sign-extend load data (ignored for stores and for dword loads).
REQ-009 req_addr  in  64  byte address.
REQ-010 req_wdata  in  64  store data, right-aligned (the low req_size bytes are used).
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  64  load result, right-aligned and extended; 0 for stores and errors.
REQ-013 rsp_error  out  1  access rejected; qualified by rsp_valid.
REQ-014 mem_address  out  64  to memory address.
REQ-015 mem_d_in  out  64  to memory write data.
REQ-016 mem_read  out  1  to memory read enable.
REQ-017 mem_write  out  1  to memory write enable.
REQ-018 mem_d_out  in  64  from memory; little-endian, combinational, settles within half a clock period.

Function
REQ-019 Only one request in flight; FSM states IDLE, RD, RMW_RD, WR, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; the request is accepted on a rising edge with req_valid&&req_ready, latching all req_* fields.
REQ-021 req_valid is ignored outside IDLE; requests are never queued.
REQ-022 Range error, checked at acceptance: req_addr > SIZE-8 -> IDLE->RESP, no memory access, rsp_error=1, rsp_rdata=0.
REQ-023 Load, accepted at edge k: IDLE->RD; mem_read=1 and mem_address=latched addr during k..k+1; mem_d_out captured at k+1; RESP with rsp_valid=1 during k+1..k+2.
REQ-024 Load result: the low 8/16/32/64 bits of the captured data, zero-extended, or sign-extended when req_signed=1.
REQ-025 Dword store, accepted at edge k: IDLE->WR; mem_write=1 and mem_d_in=wdata during k..k+1; memory updates at k+1; RESP at k+1.
REQ-026 Narrow store, accepted at edge k: IDLE->RMW_RD (read as in REQ-023); at k+1 merge the low req_size bytes of wdata into the captured dword; WR during k+1..k+2; RESP at k+2.
REQ-027 The merge SHALL leave the untouched bytes exactly equal to the values read.
REQ-028 RESP lasts exactly one cycle, then returns to IDLE; rsp_valid has no backpressure.
REQ-029 mem_read/mem_write SHALL be decoded only from the registered state, never both 1, and 0 in IDLE and RESP.
REQ-030 rsp_rdata and rsp_error SHALL hold their values until the next RESP.

Reset
REQ-031 reset_n=0 forces IDLE immediately; rsp_valid=0, rsp_error=0, rsp_rdata=0; mem_read and mem_write go to 0 combinationally; mem_address and mem_d_in go to 0.
REQ-032 Reset during WR aborts the store before the next edge; no partial write is issued and no response is given.
REQ-033 req_ready=1 on the first edge after reset_n deasserts.

Configuration
REQ-034 Macro MEM_ALIGN_CHECK_EN defined: an access whose addr is not a multiple of its size takes the REQ-022 error path.
REQ-035 Macro MEM_ALIGN_CHECK_EN undefined: misaligned accesses proceed normally, and only the range check applies.

Verification
REQ-036 Memory preloaded with mem[i]=i; dword load 0x10 -> rsp_rdata=0x1716151413121110, rsp_valid one cycle after acceptance.
REQ-037 Signed byte load 0x80 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x0000000000000080.
REQ-038 Half store 0xBEEF at 0x20, then dword load 0x20 -> 0x272625242322BEEF; store rsp_valid two cycles after acceptance.
REQ-039 Load at 0xF9 with SIZE=256 -> rsp_error=1, rsp_rdata=0, mem_read never asserted.
REQ-040 Word load 0x02: with the macro -> rsp_error=1; without it -> 0x0000000005040302.
REQ-041 reset_n pulsed low during WR of a dword store of 0xFF..FF at 0x40 -> later load of 0x40 returns 0x4746454443424140.
